// File: rtl/nec_ir_tx_if.sv
// Request/status bundle between a frame requester and the NEC IR transmitter.
// Names follow the board-level signal names used on the remote-control side.
interface nec_ir_tx_if;
    logic       Start;
    logic       Repeat;
    logic [7:0] Addr;
    logic [7:0] Cmd;
    logic       Busy;
    logic       Done;
    logic       Envelope;
    logic       IrOut;

    modport master (
        output Start, Repeat, Addr, Cmd,
        input  Busy, Done, Envelope, IrOut
    );

    modport slave (
        input  Start, Repeat, Addr, Cmd,
        output Busy, Done, Envelope, IrOut
    );
endinterface

// File: rtl/nec_ir_tx.sv
// NEC infrared frame transmitter: serialises addr/~addr/cmd/~cmd LSB-first
// (or a repeat code) and emits the envelope plus the 38 kHz modulated drive.
module nec_ir_tx #(
    parameter int UNIT_DIV    = 13500,
    parameter int CARRIER_DIV = 632,
    parameter int CNT_W       = 16
) (
    input logic        CLK,
    input logic        RST,
    nec_ir_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    localparam logic [CNT_W-1:0] UNIT_MAX = CNT_W'(UNIT_DIV - 1);
    localparam logic [CNT_W-1:0] CAR_MAX  = CNT_W'(CARRIER_DIV - 1);
    localparam logic [CNT_W-1:0] CAR_HALF = CNT_W'(CARRIER_DIV / 2);

    state_t           state, state_n;
    logic [CNT_W-1:0] pre, pre_n;
    logic [CNT_W-1:0] car, car_n;
    logic [4:0]       units, units_n;
    logic [4:0]       idx, idx_n;
    logic [31:0]      sh, sh_n;
    logic             rpt, rpt_n;
    logic             done, done_n;
    logic             env, env_n;
    logic             ir, ir_n;
    logic             unit_tick;
    logic             last;
    logic             mark_n;
    logic [4:0]       len;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            pre   <= '0;
            car   <= '0;
            units <= '0;
            idx   <= '0;
            sh    <= '0;
            rpt   <= 1'b0;
            done  <= 1'b0;
            env   <= 1'b0;
            ir    <= 1'b0;
        end else begin
            state <= state_n;
            pre   <= pre_n;
            car   <= car_n;
            units <= units_n;
            idx   <= idx_n;
            sh    <= sh_n;
            rpt   <= rpt_n;
            done  <= done_n;
            env   <= env_n;
            ir    <= ir_n;
        end
    end

    always_comb begin
        state_n   = state;
        unit_tick = (pre == UNIT_MAX);
        pre_n     = unit_tick ? '0 : pre + CNT_W'(1);
        units_n   = unit_tick ? units + 5'd1 : units;
        car_n     = (car == CAR_MAX) ? '0 : car + CNT_W'(1);
        idx_n     = idx;
        sh_n      = sh;
        rpt_n     = rpt;
        done_n    = 1'b0;
        len       = 5'd1;

        // Length in time units of the state currently being held.
        unique case (state)
            LEAD_MARK:  len = 5'd16;
            LEAD_SPACE: len = rpt ? 5'd4 : 5'd8;
            BIT_SPACE:  len = sh[0] ? 5'd3 : 5'd1;
            default:    len = 5'd1;
        endcase
        last = unit_tick && (units == len - 5'd1);

        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    sh_n    = {~bus.Cmd, bus.Cmd, ~bus.Addr, bus.Addr};
                    rpt_n   = bus.Repeat;
                    state_n = LEAD_MARK;
                end
            end
            LEAD_MARK: begin
                if (last) state_n = LEAD_SPACE;
            end
            LEAD_SPACE: begin
                if (last) begin
                    idx_n   = '0;
                    state_n = rpt ? STOP_MARK : BIT_MARK;
                end
            end
            BIT_MARK: begin
                if (last) state_n = BIT_SPACE;
            end
            BIT_SPACE: begin
                if (last) begin
                    sh_n    = {1'b0, sh[31:1]};
                    idx_n   = idx + 5'd1;
                    state_n = (idx == 5'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK: begin
                if (last) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state || state == IDLE) begin
            pre_n   = '0;
            units_n = '0;
        end

        // Every burst restarts the carrier so it begins on the high half.
        mark_n = (state_n == LEAD_MARK) || (state_n == BIT_MARK) ||
                 (state_n == STOP_MARK);
        if ((mark_n && state_n != state) || state_n == IDLE) car_n = '0;

        env_n = mark_n;
        ir_n  = mark_n && (car_n < CAR_HALF);
    end

    assign bus.Busy     = (state != IDLE);
    assign bus.Done     = done;
    assign bus.Envelope = env;
    assign bus.IrOut    = ir;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Bench for nec_ir_tx: two instances (carrier divide 2 and 4) share stimulus
// and are compared per cycle against a segment-list model of the NEC frame.
module tb_nec_ir_tx;

    localparam int UD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rpt;
    logic [7:0] addr;
    logic [7:0] cmd;

    always #5 clk = ~clk;

    nec_ir_tx_if bus2 ();
    nec_ir_tx_if bus4 ();

    assign bus2.Start  = start;
    assign bus2.Repeat = rpt;
    assign bus2.Addr   = addr;
    assign bus2.Cmd    = cmd;
    assign bus4.Start  = start;
    assign bus4.Repeat = rpt;
    assign bus4.Addr   = addr;
    assign bus4.Cmd    = cmd;

    nec_ir_tx #(.UNIT_DIV(UD), .CARRIER_DIV(2), .CNT_W(16)) dut2 (
        .CLK(clk), .RST(rst), .bus(bus2)
    );

    nec_ir_tx #(.UNIT_DIV(UD), .CARRIER_DIV(4), .CNT_W(16)) dut4 (
        .CLK(clk), .RST(rst), .bus(bus4)
    );

    int n_chk  = 0;
    int n_fail = 0;

    bit exp_env[$];
    bit exp_ir2[$];
    bit exp_ir4[$];

    // Frame as alternating mark/space segments (in units), then per cycle.
    function automatic void build(input logic [7:0] a, input logic [7:0] c,
                                  input logic r);
        int          seg[$];
        logic [31:0] data;
        data = {~c, c, ~a, a};
        seg.push_back(16);
        seg.push_back(r ? 4 : 8);
        if (!r) begin
            for (int i = 0; i < 32; i++) begin
                seg.push_back(1);
                seg.push_back(data[i] ? 3 : 1);
            end
        end
        seg.push_back(1);
        exp_env.delete();
        exp_ir2.delete();
        exp_ir4.delete();
        for (int s = 0; s < seg.size(); s++) begin
            for (int j = 0; j < seg[s] * UD; j++) begin
                bit m;
                m = (s % 2 == 0);
                exp_env.push_back(m);
                exp_ir2.push_back(m && ((j % 2) < 1));
                exp_ir4.push_back(m && ((j % 4) < 2));
            end
        end
    endfunction

    // Sends one frame starting at the current negedge; returns at the
    // negedge of the Done cycle with Start low.
    task automatic run_frame(input string tag, input logic [7:0] a,
                             input logic [7:0] c, input logic r,
                             input bit junk);
        int   len, bad_env, bad_ir2, bad_ir4, bad_done, busy_cnt;
        int   k_env, k_ir2, k_ir4;
        bit   g_env, g_ir2, g_ir4;
        logic [3:0] end_v;
        build(a, c, r);
        len = exp_env.size();
        bad_env = 0; bad_ir2 = 0; bad_ir4 = 0; bad_done = 0; busy_cnt = 0;
        k_env = 0; k_ir2 = 0; k_ir4 = 0;
        g_env = 0; g_ir2 = 0; g_ir4 = 0;
        addr = a; cmd = c; rpt = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (bus2.Envelope !== exp_env[k] || bus4.Envelope !== exp_env[k]) begin
                if (bad_env == 0) begin k_env = k; g_env = bus2.Envelope; end
                bad_env++;
            end
            if (bus2.IrOut !== exp_ir2[k]) begin
                if (bad_ir2 == 0) begin k_ir2 = k; g_ir2 = bus2.IrOut; end
                bad_ir2++;
            end
            if (bus4.IrOut !== exp_ir4[k]) begin
                if (bad_ir4 == 0) begin k_ir4 = k; g_ir4 = bus4.IrOut; end
                bad_ir4++;
            end
            if (bus2.Done !== 1'b0 || bus4.Done !== 1'b0) bad_done++;
            if (bus2.Busy === 1'b1 && bus4.Busy === 1'b1) busy_cnt++;
            if (junk && k < len - 1 && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                addr = 8'($urandom);
                cmd = 8'($urandom);
                rpt = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        end_v = {bus2.Done, bus4.Done, bus2.Busy, bus4.Busy};

        n_chk++;
        if (bad_env !== 0) begin
            n_fail++;
            $display("FAIL %s envelope: %0d bad cycles, first cycle %0d got %b want %b",
                     tag, bad_env, k_env, g_env, exp_env[k_env]);
        end
        n_chk++;
        if (bad_ir2 !== 0) begin
            n_fail++;
            $display("FAIL %s irout_div2: %0d bad cycles, first cycle %0d got %b want %b",
                     tag, bad_ir2, k_ir2, g_ir2, exp_ir2[k_ir2]);
        end
        n_chk++;
        if (bad_ir4 !== 0) begin
            n_fail++;
            $display("FAIL %s irout_div4: %0d bad cycles, first cycle %0d got %b want %b",
                     tag, bad_ir4, k_ir4, g_ir4, exp_ir4[k_ir4]);
        end
        n_chk++;
        if (bad_done !== 0) begin
            n_fail++;
            $display("FAIL %s early_done: got %0d cycles with Done, want 0", tag, bad_done);
        end
        n_chk++;
        if (busy_cnt !== (r ? 21 * UD : 121 * UD)) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d want %0d",
                     tag, busy_cnt, r ? 21 * UD : 121 * UD);
        end
        n_chk++;
        if (end_v !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s done_cycle: got done/busy %b want 1100", tag, end_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; rpt = 1'b0; addr = '0; cmd = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus2.Busy, bus2.Done, bus2.Envelope, bus2.IrOut,
             bus4.Busy, bus4.Done, bus4.Envelope, bus4.IrOut} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b%b%b%b want 0000",
                     bus2.Busy, bus2.Done, bus2.Envelope, bus2.IrOut);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus2.Busy !== 1'b0 || bus2.Envelope !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy %b env %b want 0 0",
                     bus2.Busy, bus2.Envelope);
        end
    endtask

    task automatic test_full_frame();
        run_frame("full_0x00_0x45", 8'h00, 8'h45, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++;
        if (bus2.Done !== 1'b0 || bus2.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got done %b busy %b want 0 0",
                     bus2.Done, bus2.Busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_repeat();
        run_frame("repeat", 8'h12, 8'h34, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int extra;
        run_frame("busy_ignore", 8'hA5, 8'h3C, 1'b0, 1'b1);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus2.Busy !== 1'b0 || bus2.Done !== 1'b0) extra++;
        end
        n_chk++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_ignore_after: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        addr = 8'h5A; cmd = 8'hC3; rpt = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (140) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus2.Envelope, bus2.IrOut, bus2.Busy,
             bus4.Envelope, bus4.IrOut, bus4.Busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got env %b ir %b busy %b want 0 0 0",
                     bus2.Envelope, bus2.IrOut, bus2.Busy);
        end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus2.Done !== 1'b0 || bus4.Done !== 1'b0) seen++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus2.Done !== 1'b0 || bus2.Busy !== 1'b0) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done/busy cycles want 0", seen);
        end
        run_frame("after_reset", 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_first", 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        run_frame("b2b_second", 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        run_frame("b2b_third", 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("random_%0d", i), 8'($urandom), 8'($urandom),
                      1'($urandom_range(0, 2) == 0), 1'b0);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_repeat();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
